// File: rtl/sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_buffer
// Purpose  : Assembles 3x3 pixel neighbourhoods from a raster pixel stream
//            using two line memories; optional window counter is enabled by
//            defining SOBEL_WINDOW_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_buffer #(
  parameter int MAX_WIDTH = 640,
  parameter int CW        = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          start,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] length,
  input  logic [7:0]    pixel_in,
  input  logic          pixel_valid,
  output logic [71:0]   window_out,
  output logic          window_valid,
  output logic          busy,
  output logic          frame_done,
  output logic          size_err
`ifdef SOBEL_WINDOW_CNT_EN
  , output logic [31:0] win_count
`endif
);

  localparam int            AW     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CW-1:0] C_MAXW = CW'(MAX_WIDTH);
  localparam logic [CW-1:0] C_MIN  = CW'(3);
  localparam logic [CW-1:0] C_TWO  = CW'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] wm1_q, lm1_q, col_q, row_q;
  logic [CW-1:0] col_d, row_d;
  logic [71:0]   win_q, win_d;
  logic          window_valid_q, busy_q, frame_done_q, size_err_q;
  logic [7:0]    line0_q [MAX_WIDTH];
  logic [7:0]    line1_q [MAX_WIDTH];
  logic [7:0]    top_rd, mid_rd;
  logic [AW-1:0] addr;
  logic          accept, wrap, last_pix, emit, dims_ok;
`ifdef SOBEL_WINDOW_CNT_EN
  logic [31:0]   win_count_q;
`endif

  assign addr = col_q[AW-1:0];

  always_comb begin
    accept   = pixel_valid && ((state_q == FILL) || (state_q == STREAM));
    top_rd   = line0_q[addr];
    mid_rd   = line1_q[addr];
    // Shift every window row left by one pixel; new right column enters.
    win_d    = {win_q[63:48], top_rd, win_q[39:24], mid_rd, win_q[15:0], pixel_in};
    wrap     = (col_q == wm1_q);
    col_d    = wrap ? '0 : col_q + CW'(1);
    row_d    = wrap ? row_q + CW'(1) : row_q;
    last_pix = accept && wrap && (row_q == lm1_q);
    emit     = accept && (row_q >= C_TWO) && (col_q >= C_TWO);
    dims_ok  = (width >= C_MIN) && (length >= C_MIN) && (width <= C_MAXW);
  end

  // Line memories: row-1 moves into the row-2 slot as the new pixel lands.
  always_ff @(posedge HCLK) begin
    if (accept) begin
      line0_q[addr] <= mid_rd;
      line1_q[addr] <= pixel_in;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q        <= IDLE;
      wm1_q          <= '0;
      lm1_q          <= '0;
      col_q          <= '0;
      row_q          <= '0;
      win_q          <= '0;
      window_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      size_err_q     <= 1'b0;
`ifdef SOBEL_WINDOW_CNT_EN
      win_count_q    <= '0;
`endif
    end else begin
      window_valid_q <= emit;
      frame_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (dims_ok) begin
              wm1_q      <= width - CW'(1);
              lm1_q      <= length - CW'(1);
              col_q      <= '0;
              row_q      <= '0;
              busy_q     <= 1'b1;
              size_err_q <= 1'b0;
              state_q    <= FILL;
`ifdef SOBEL_WINDOW_CNT_EN
              win_count_q <= '0;
`endif
            end else begin
              size_err_q <= 1'b1;
            end
          end
        end
        FILL, STREAM: begin
          if (accept) begin
            win_q <= win_d;
            col_q <= col_d;
            row_q <= row_d;
            if (last_pix) begin
              state_q      <= DONE;
              frame_done_q <= 1'b1;
            end else if ((state_q == FILL) && (row_d == C_TWO) && (col_d == '0)) begin
              state_q <= STREAM;
            end
          end
`ifdef SOBEL_WINDOW_CNT_EN
          if (emit) begin
            win_count_q <= win_count_q + 32'd1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign window_out   = win_q;
  assign window_valid = window_valid_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign size_err     = size_err_q;
`ifdef SOBEL_WINDOW_CNT_EN
  assign win_count    = win_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_buffer
// Purpose  : Self-checking bench for sobel_window_buffer; windows are derived
//            from a stored image, independent of the line-memory structure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_window_buffer;
  localparam int MAXW = 640;
  localparam int CW   = 16;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] width = '0;
  logic [CW-1:0] length = '0;
  logic [7:0]    pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic [71:0]   window_out;
  logic          window_valid, busy, frame_done, size_err;
`ifdef SOBEL_WINDOW_CNT_EN
  logic [31:0]   win_count;
`endif

  sobel_window_buffer #(.MAX_WIDTH(MAXW), .CW(CW)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .start       (start),
    .width       (width),
    .length      (length),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .window_out  (window_out),
    .window_valid(window_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .size_err    (size_err)
`ifdef SOBEL_WINDOW_CNT_EN
    , .win_count (win_count)
`endif
  );

  always #5 HCLK = ~HCLK;

  int          tests = 0;
  int          fails = 0;
  int          win_seen = 0;
  bit          chk_en = 1'b0;
  bit          exp_wv = 1'b0;
  bit          exp_fd = 1'b0;
  logic [71:0] exp_win = '0;
  logic [71:0] first_win = '0;
  logic [71:0] last_win = '0;
  logic [7:0]  img [4096];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single compare process: every cycle checks the strobes, and the window
  // content whenever the model says a window is due.
  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("window_valid", 72'(window_valid), 72'(exp_wv));
      chk("frame_done", 72'(frame_done), 72'(exp_fd));
      if (exp_wv) chk("window_out", window_out, exp_win);
      if (window_valid) begin
        if (win_seen == 0) first_win = window_out;
        last_win = window_out;
        win_seen++;
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] pix, input bit q,
                       input bit last, input logic [71:0] win);
    @(negedge HCLK);
    start       = 1'b0;
    pixel_valid = v;
    pixel_in    = pix;
    @(posedge HCLK);
    #1;
    exp_wv  = v && q;
    exp_fd  = v && last;
    exp_win = win;
  endtask

  task automatic do_start(input int w, input int l);
    @(negedge HCLK);
    start       = 1'b1;
    width       = CW'(w);
    length      = CW'(l);
    pixel_valid = 1'b0;
    @(posedge HCLK);
    #1;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
  endtask

  // mode 0: back-to-back ramp, 1: ramp with a gap before every pixel,
  // 2: random pixels with random gaps (junk data on pixel_in during gaps)
  task automatic run_frame(input int w, input int l, input int mode);
    int          n, r, c, gaps;
    bit          q, last;
    logic [71:0] win;
    n = w * l;
    for (int i = 0; i < n; i++) img[i] = (mode == 2) ? 8'($urandom) : 8'(i);
    win_seen = 0;
    do_start(w, l);
    chk("busy_after_start", 72'(busy), 72'd1);
    for (int i = 0; i < n; i++) begin
      if (mode == 1) drive(1'b0, 8'hEE, 1'b0, 1'b0, '0);
      if (mode == 2) begin
        gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int g = 0; g < gaps; g++) drive(1'b0, 8'($urandom), 1'b0, 1'b0, '0);
      end
      r    = i / w;
      c    = i % w;
      q    = (r >= 2) && (c >= 2);
      last = (i == n - 1);
      win  = '0;
      if (q) begin
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            win[71 - 8*(dr*3 + dc) -: 8] = img[(r - 2 + dr) * w + (c - 2 + dc)];
      end
      drive(1'b1, img[i], q, last, win);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, '0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, '0);
    chk("busy_after_frame", 72'(busy), 72'd0);
    chk("window_count", 72'(win_seen), 72'((w - 2) * (l - 2)));
  endtask

  task automatic check_4x4_literals();
    chk("first_win_4x4", first_win, 72'h000102_040506_08090A);
    chk("last_win_4x4", last_win, 72'h050607_090A0B_0D0E0F);
    chk("nwin_4x4", 72'(win_seen), 72'd4);
  endtask

  initial begin
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    chk_en = 1'b1;
    chk("rst_window_out", window_out, 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_size_err", 72'(size_err), 72'd0);
    @(negedge HCLK);
    HRESET = 1'b0;

    run_frame(4, 4, 0);
    check_4x4_literals();

    run_frame(4, 4, 1);
    check_4x4_literals();

    // Illegal sizes, then a legal 3x3 clears the sticky error
    do_start(2, 5);
    chk("size_err_w2", 72'(size_err), 72'd1);
    chk("busy_w2", 72'(busy), 72'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, '0);
    do_start(MAXW + 1, 4);
    chk("size_err_wmax", 72'(size_err), 72'd1);
    do_start(5, 2);
    chk("size_err_l2", 72'(size_err), 72'd1);
    run_frame(3, 3, 0);
    chk("size_err_clear", 72'(size_err), 72'd0);
    chk("win_3x3", first_win, 72'h000102_030405_060708);
    chk("nwin_3x3", 72'(win_seen), 72'd1);

    run_frame(MAXW, 3, 0);
    chk("maxw_bottom_row", 72'(last_win[23:0]), 72'h7D7E7F);
    chk("maxw_nwin", 72'(win_seen), 72'(MAXW - 2));

    // Mid-frame reset after pixel 7, then a clean rerun
    do_start(4, 4);
    for (int i = 0; i < 8; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, '0);
    @(negedge HCLK);
    HRESET      = 1'b1;
    pixel_valid = 1'b0;
    @(posedge HCLK);
    #1;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    chk("mid_rst_window_out", window_out, 72'd0);
    chk("mid_rst_valid", 72'(window_valid), 72'd0);
    chk("mid_rst_busy", 72'(busy), 72'd0);
    chk("mid_rst_done", 72'(frame_done), 72'd0);
    chk("mid_rst_size_err", 72'(size_err), 72'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    run_frame(4, 4, 0);
    check_4x4_literals();

`ifdef SOBEL_WINDOW_CNT_EN
    run_frame(5, 4, 0);
    chk("win_count_5x4", 72'(win_count), 72'd6);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, '0);
    chk("win_count_held", 72'(win_count), 72'd6);
    run_frame(3, 3, 0);
    chk("win_count_3x3", 72'(win_count), 72'd1);
`endif

    for (int k = 0; k < 6; k++) begin
      run_frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 8)), 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
